// File: rtl/jk_bank_sequencer.sv
// Round-robin command sequencer that drives a bank of JK flip-flops.
// Each command becomes per-bit J/K drive vectors. COUNT steps read the
// bank's Q outputs back to build the increment toggle mask.
module jk_bank_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] jk_j,
   output logic [WIDTH-1:0] jk_k,
   output logic             busy,
   output logic             done,
   output logic             grant_id
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;

   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_SET    = 3'd2;
   localparam logic [2:0] OP_LOAD   = 3'd3;
   localparam logic [2:0] OP_TOGGLE = 3'd4;
   localparam logic [2:0] OP_COUNT  = 3'd5;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             gid_q, gid_d;
   logic             last_q, last_d;

   logic             grant0_c, grant1_c;
   logic [2:0]       sel_op_c;
   logic [WIDTH-1:0] sel_data_c;
   logic [WIDTH-1:0] q_mask_c;
   logic [WIDTH-1:0] sel_mask_c;

   // Toggle mask of a binary increment: bit i flips when all lower bits are one.
   function automatic logic [WIDTH-1:0] inc_mask(input logic [WIDTH-1:0] q);
      logic [WIDTH-1:0] m;
      m[0] = 1'b1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         m[i] = m[i-1] & q[i-1];
      end
      return m;
   endfunction

   // Round-robin arbitration: on contention the requester not served last wins.
   always_comb begin
      grant0_c   = req0_valid & (~req1_valid | last_q);
      grant1_c   = req1_valid & ~grant0_c;
      sel_op_c   = grant1_c ? req1_op   : req0_op;
      sel_data_c = grant1_c ? req1_data : req0_data;
      q_mask_c   = inc_mask(q_in);
      sel_mask_c = q_mask_c;
   end

   assign req0_ready = (state_q == ST_IDLE) & grant0_c;
   assign req1_ready = (state_q == ST_IDLE) & grant1_c;

   // Next-state, drive pattern and step counter.
   always_comb begin
      state_d = state_q;
      j_d     = '0;
      k_d     = '0;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      gid_d   = gid_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (grant0_c | grant1_c) begin
               gid_d  = grant1_c;
               last_d = grant1_c;
               cnt_d  = (sel_op_c == OP_COUNT) ? sel_data_c : WIDTH'(1);
               if ((sel_op_c == OP_COUNT) && (sel_data_c == '0)) begin
                  // Zero-step count completes without ever driving the bank.
                  state_d = ST_SETTLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_DRIVE;
                  case (sel_op_c)
                     OP_CLEAR:  begin j_d = '0;         k_d = '1;          end
                     OP_SET:    begin j_d = '1;         k_d = '0;          end
                     OP_LOAD:   begin j_d = sel_data_c; k_d = ~sel_data_c; end
                     OP_TOGGLE: begin j_d = sel_data_c; k_d = sel_data_c;  end
                     OP_COUNT:  begin j_d = sel_mask_c; k_d = sel_mask_c;  end
                     default:   begin j_d = '0;         k_d = '0;          end
                  endcase
               end
            end
         end
         ST_DRIVE: begin
            state_d = ST_SETTLE;
            cnt_d   = cnt_q - WIDTH'(1);
            done_d  = (cnt_q == WIDTH'(1));
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRIVE;
               j_d     = q_mask_c;
               k_d     = q_mask_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         j_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gid_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         gid_q   <= gid_d;
         last_q  <= last_d;
      end
   end

   assign jk_j     = j_q;
   assign jk_k     = k_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign grant_id = gid_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: a behavioural JK bank closes the Q loop and
// expected results come from register-level arithmetic on the bank value.
module tb_jk_bank_sequencer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       req0_valid, req1_valid;
   logic [2:0] req0_op, req1_op;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic [7:0] bank_q, jk_j, jk_k;
   logic       busy, done, grant_id;
   logic       load_en;
   logic [7:0] load_val;

   int checks = 0;
   int errors = 0;
   int last_m = 1;

   jk_bank_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_data(req1_data), .req1_ready(req1_ready),
      .q_in(bank_q), .jk_j(jk_j), .jk_k(jk_k),
      .busy(busy), .done(done), .grant_id(grant_id)
   );

   // JK cell bank: J=1 sets, K=1 clears, both toggle, neither holds.
   always @(posedge clk) begin
      if (load_en) bank_q <= load_val;
      else         bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
   end

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bank value after a whole command.
   function automatic logic [7:0] exp_final(input logic [2:0] op, input logic [7:0] d, input logic [7:0] q);
      case (op)
         3'd1:    return 8'h00;
         3'd2:    return 8'hFF;
         3'd3:    return d;
         3'd4:    return q ^ d;
         3'd5:    return 8'(q + d);
         default: return q;
      endcase
   endfunction

   // Bits that change when q is incremented by one.
   function automatic logic [7:0] flip_bits(input logic [7:0] q);
      return q ^ 8'(q + 8'd1);
   endfunction

   // {J,K} of the first drive cycle.
   function automatic logic [15:0] exp_jk(input logic [2:0] op, input logic [7:0] d, input logic [7:0] q);
      case (op)
         3'd1:    return {8'h00, 8'hFF};
         3'd2:    return {8'hFF, 8'h00};
         3'd3:    return {d, ~d};
         3'd4:    return {d, d};
         3'd5:    return {flip_bits(q), flip_bits(q)};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic set_req(input int r, input logic v, input logic [2:0] op, input logic [7:0] d);
      if (r == 0) begin req0_valid = v; req0_op = op; req0_data = d; end
      else        begin req1_valid = v; req1_op = op; req1_data = d; end
   endtask

   function automatic logic rdy_of(input int r);
      return (r == 0) ? req0_ready : req1_ready;
   endfunction

   task automatic preload(input logic [7:0] v);
      @(negedge clk);
      load_en = 1'b1; load_val = v;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Issue one command from requester r and follow it to completion.
   task automatic do_cmd(input int r, input logic [2:0] op, input logic [7:0] d);
      logic [7:0]  qexp;
      logic [15:0] jk;
      int          lat, exp_lat, w;
      @(negedge clk);
      set_req(r, 1'b1, op, d);
      #1;
      w = 0;
      while (!rdy_of(r) && w < 20) begin
         @(negedge clk); #1; w++;
      end
      chk1("accept_ready", rdy_of(r), 1'b1);
      chk1("ready_excl", req0_ready & req1_ready, 1'b0);
      last_m  = r;
      qexp    = exp_final(op, d, bank_q);
      jk      = exp_jk(op, d, bank_q);
      exp_lat = (op == 3'd5) ? ((d == 8'd0) ? 1 : 2 * int'(d)) : 2;
      @(negedge clk);
      set_req(r, 1'b0, 3'd0, 8'd0);
      lat = 1;
      if (exp_lat == 1) begin
         chk8("c0_j", jk_j, 8'h00);
         chk8("c0_k", jk_k, 8'h00);
      end else begin
         chk8("drv_j", jk_j, jk[15:8]);
         chk8("drv_k", jk_k, jk[7:0]);
         chk1("drv_done", done, 1'b0);
      end
      chk1("busy_hi", busy, 1'b1);
      while (!done && lat < 600) begin
         @(negedge clk);
         lat++;
         if (lat % 2 == 0) begin
            chk8("settle_j", jk_j, 8'h00);
            chk8("settle_k", jk_k, 8'h00);
         end else if (op == 3'd5) begin
            chk8("cnt_mask_j", jk_j, flip_bits(bank_q));
            chk8("cnt_mask_k", jk_k, flip_bits(bank_q));
         end
      end
      chki("latency", lat, exp_lat);
      chk8("q_final", bank_q, qexp);
      chk1("grant_id", grant_id, (r != 0));
      @(negedge clk);
      chk1("busy_after", busy, 1'b0);
      chk1("done_single", done, 1'b0);
      set_req(r, 1'b1, 3'd0, 8'd0);
      #1;
      chk1("ready_again", rdy_of(r), 1'b1);
      set_req(r, 1'b0, 3'd0, 8'd0);
   endtask

   initial begin
      int n_acc, prev_g;
      logic g_exp;
      logic [2:0] op;
      logic [7:0] d;
      int r;

      reset = 1'b0; load_en = 1'b1; load_val = 8'h00;
      set_req(0, 1'b0, 3'd0, 8'd0);
      set_req(1, 1'b0, 3'd0, 8'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1; load_en = 1'b0;
      chk8("rst_j", jk_j, 8'h00);
      chk8("rst_k", jk_k, 8'h00);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_gid", grant_id, 1'b0);

      // LOAD 0xA5
      do_cmd(0, 3'd3, 8'hA5);

      // Contention: req0 SET vs req1 CLEAR, grants must alternate.
      @(negedge clk);
      set_req(0, 1'b1, 3'd2, 8'h00);
      set_req(1, 1'b1, 3'd1, 8'h00);
      n_acc = 0; prev_g = -1;
      for (int c = 0; c < 14; c++) begin
         #1;
         chk1("alt_excl", req0_ready & req1_ready, 1'b0);
         if (req0_ready | req1_ready) begin
            if (prev_g >= 0) begin
               chk8("alt_q", bank_q, (prev_g == 0) ? 8'hFF : 8'h00);
               chk1("alt_gid", grant_id, (prev_g != 0));
            end
            g_exp = (last_m == 0);
            chk1("alt_grant", req1_ready, g_exp);
            last_m = g_exp ? 1 : 0;
            prev_g = last_m;
            n_acc++;
         end
         @(negedge clk);
      end
      set_req(0, 1'b0, 3'd0, 8'd0);
      set_req(1, 1'b0, 3'd0, 8'd0);
      chki("alt_accepts", n_acc, 5);
      repeat (2) @(negedge clk);

      // COUNT 3 from 0xFE, then zero-step COUNT
      preload(8'hFE);
      do_cmd(0, 3'd5, 8'd3);
      do_cmd(1, 3'd5, 8'd0);

      // Reset during the second step of COUNT 5
      preload(8'h10);
      @(negedge clk);
      set_req(0, 1'b1, 3'd5, 8'd5);
      #1;
      chk1("rc_accept", req0_ready, 1'b1);
      @(negedge clk);
      set_req(0, 1'b0, 3'd0, 8'd0);
      repeat (2) @(negedge clk);
      chk1("rc_busy_pre", busy, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk8("rc_j", jk_j, 8'h00);
      chk8("rc_k", jk_k, 8'h00);
      chk1("rc_busy", busy, 1'b0);
      chk1("rc_done", done, 1'b0);
      @(negedge clk);
      chk1("rc_done_next", done, 1'b0);
      set_req(0, 1'b1, 3'd0, 8'd0);
      set_req(1, 1'b1, 3'd0, 8'd0);
      #1;
      chk1("rc_prio0", req0_ready, 1'b1);
      chk1("rc_prio1", req1_ready, 1'b0);
      last_m = 0;
      @(negedge clk);
      set_req(0, 1'b0, 3'd0, 8'd0);
      set_req(1, 1'b0, 3'd0, 8'd0);
      repeat (3) @(negedge clk);

      // Reserved op 7, then TOGGLE 0x0F on 0x33
      preload(8'h33);
      do_cmd(1, 3'd7, 8'h5A);
      do_cmd(0, 3'd4, 8'h0F);

      // Randomized commands against the model
      for (int i = 0; i < 25; i++) begin
         r  = int'($urandom_range(1, 0));
         op = 3'($urandom_range(7, 0));
         d  = 8'($urandom_range(255, 0));
         if (op == 3'd5) d = 8'($urandom_range(6, 0));
         if ($urandom_range(3, 0) == 0) preload(8'($urandom_range(255, 0)));
         do_cmd(r, op, d);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
